// File: rtl/bram_burst_reader.sv
// Burst reader for one port of a dual-port block RAM. It fetches LEN bytes from BASE_ADDR, wrapping at the top address, and streams them out as valid/ready.
// Latency: START accepted in cycle 0, RAM_EN in cycle 1, first DVALID in cycle 3.
// Backpressure: reads are credit-limited to the 4-entry output FIFO, so DREADY low stalls RAM_EN and nothing is dropped.
module bram_burst_reader #(
    parameter int ADDR_WIDTH = 9,
    parameter int DATA_WIDTH = 8,
    parameter int LEN_WIDTH  = 10
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [LEN_WIDTH-1:0]  len,
    output logic                  busy,
    output logic                  done,
    output logic                  ram_en,
    output logic                  ram_we,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    input  logic [DATA_WIDTH-1:0] ram_do,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  dvalid,
    input  logic                  dready,
    output logic                  dlast
);
    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] READ    = 2'd1;
    localparam logic [1:0] DRAIN   = 2'd2;
    localparam logic [2:0] CREDITS = 3'd4;

    logic [1:0]            state;
    logic [LEN_WIDTH-1:0]  remaining;
    logic [LEN_WIDTH-1:0]  len_q;
    logic [LEN_WIDTH-1:0]  out_cnt;
    logic                  cap_vld;
    logic [2:0]            fifo_count;
    logic                  fifo_empty;
    logic [DATA_WIDTH-1:0] head_dat;
    logic                  idle_start;
    logic                  accept;
    logic                  zero_start;
    logic                  issue;
    logic                  pop;
    logic                  last_pop;
    logic [2:0]            pending;

    assign ram_we     = 1'b0;
    assign idle_start = start & ~busy & (state == IDLE);
    assign accept     = idle_start & (len != '0);
    assign zero_start = idle_start & (len == '0);

    // Bytes already queued, being captured, or being read all hold a FIFO slot.
    assign pending = fifo_count + 3'(ram_en) + 3'(cap_vld);
    assign issue   = (state == READ) & (remaining != '0) & (pending < CREDITS);

    assign dvalid   = ~fifo_empty;
    assign dout     = fifo_empty ? '0 : head_dat;
    assign pop      = dvalid & dready;
    assign dlast    = dvalid & (out_cnt == len_q - LEN_WIDTH'(1));
    assign last_pop = pop & dlast;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            ram_en    <= 1'b0;
            ram_addr  <= '0;
            remaining <= '0;
            len_q     <= '0;
            out_cnt   <= '0;
            cap_vld   <= 1'b0;
        end else begin
            done    <= zero_start | last_pop;
            ram_en  <= accept | issue;
            cap_vld <= ram_en;
            // BUSY stays high through the DONE cycle and drops right after it.
            if (accept) begin
                busy <= 1'b1;
            end else if (done) begin
                busy <= 1'b0;
            end
            if (pop) begin
                out_cnt <= out_cnt + LEN_WIDTH'(1);
            end
            case (state)
                IDLE: begin
                    if (accept) begin
                        state     <= READ;
                        len_q     <= len;
                        remaining <= len - LEN_WIDTH'(1);
                        ram_addr  <= base_addr;
                        out_cnt   <= '0;
                    end
                end
                READ: begin
                    if (issue) begin
                        remaining <= remaining - LEN_WIDTH'(1);
                        ram_addr  <= ram_addr + ADDR_WIDTH'(1);
                    end
                    if ((remaining == '0) || (issue && (remaining == LEN_WIDTH'(1)))) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (last_pop) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    bram_burst_fifo #(
        .WIDTH      (DATA_WIDTH),
        .DEPTH_LOG2 (2)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (cap_vld),
        .push_dat (ram_do),
        .pop      (pop),
        .head_dat (head_dat),
        .count    (fifo_count),
        .empty    (fifo_empty)
    );
endmodule

// Generic synchronous FIFO with the head word visible combinationally.
// Latency: a word pushed in cycle N becomes visible at the head in cycle N+1.
// Backpressure: the caller meters pushes by credits; a push while full is dropped.
module bram_burst_fifo #(
    parameter int WIDTH      = 8,
    parameter int DEPTH_LOG2 = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push,
    input  logic [WIDTH-1:0]      push_dat,
    input  logic                  pop,
    output logic [WIDTH-1:0]      head_dat,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  empty
);
    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [WIDTH-1:0]      mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic                  full;
    logic                  do_push;
    logic                  do_pop;

    assign empty    = (count == '0);
    assign full     = (count == (DEPTH_LOG2 + 1)'(DEPTH));
    assign do_push  = push & ~full;
    assign do_pop   = pop & ~empty;
    assign head_dat = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + DEPTH_LOG2'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + DEPTH_LOG2'(1);
            end
            count <= count + (DEPTH_LOG2 + 1)'(do_push) - (DEPTH_LOG2 + 1)'(do_pop);
        end
    end
endmodule

// File: tb/tb_bram_burst_reader.sv
// Bench for bram_burst_reader: a scoreboarded RAM model, cycle-exact hand sequences, and a table of bursts.
module tb_bram_burst_reader;
    typedef struct packed {
        logic [7:0] dat;
        logic       last;
    } exp_t;

    typedef struct {
        logic [8:0] base;
        logic [9:0] len;
        int         mode;   // 0: ready always, 1: random, 2: random with a 10-cycle stall
        bit         poke;   // pulse START mid-burst
        logic [7:0] first;
        logic [7:0] lastb;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       start = 1'b0;
    logic [8:0] base_addr = '0;
    logic [9:0] len = '0;
    logic       busy, done, ram_en, ram_we, dvalid, dlast;
    logic       dready = 1'b0;
    logic [8:0] ram_addr;
    logic [7:0] ram_do = '0;
    logic [7:0] dout;

    int errors = 0;
    int checks = 0;

    logic [7:0] mem [0:511];
    exp_t       exp_q [$];
    logic [8:0] addr_q [$];

    bit         mon_en = 1'b0;
    int         issued, popped, outstanding_s, rx_cnt, done_cnt, dlast_cnt, run, max_run;
    logic       ram_en_s;
    logic [7:0] first_dout, last_dout, stall_dout;
    logic       stall_prev, stall_last;
    exp_t       m_e;

    vec_t       vecs [5];
    logic [12:0] basic_tab [9];

    always #5 clk = ~clk;

    bram_burst_reader dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .base_addr (base_addr),
        .len       (len),
        .busy      (busy),
        .done      (done),
        .ram_en    (ram_en),
        .ram_we    (ram_we),
        .ram_addr  (ram_addr),
        .ram_do    (ram_do),
        .dout      (dout),
        .dvalid    (dvalid),
        .dready    (dready),
        .dlast     (dlast)
    );

    always @(posedge clk) begin
        if (ram_en) ram_do <= mem[ram_addr];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail(input string name, input logic [31:0] act);
        checks++;
        errors++;
        $display("FAIL %s: got 0x%0h expected nothing", name, act);
    endtask

    task automatic push_exp(input logic [8:0] b, input logic [9:0] l);
        logic [8:0] a;
        exp_t e;
        for (int i = 0; i < int'(l); i++) begin
            a = b + 9'(i);
            addr_q.push_back(a);
            e.dat  = mem[a];
            e.last = (i == int'(l) - 1);
            exp_q.push_back(e);
        end
    endtask

    task automatic clear_stats();
        issued = 0; popped = 0; rx_cnt = 0; done_cnt = 0; dlast_cnt = 0;
        run = 0; max_run = 0; stall_prev = 1'b0;
        first_dout = '0; last_dout = '0;
    endtask

    // Scoreboard monitor: reads, credits, stream order, stall stability.
    always @(negedge clk) begin
        if (mon_en) begin
            issued        = issued + int'(ram_en);
            outstanding_s = issued - popped;
            ram_en_s      = ram_en;
            check("credit_le4", 32'(outstanding_s <= 4), 1);
            if (ram_en) begin
                if (addr_q.size() == 0) fail("extra_read", 32'(ram_addr));
                else check("ram_addr", 32'(ram_addr), 32'(addr_q.pop_front()));
            end
            if (stall_prev) begin
                check("stall_dvalid", 32'(dvalid), 1);
                check("stall_dout", 32'(dout), 32'(stall_dout));
                check("stall_dlast", 32'(dlast), 32'(stall_last));
            end
            if (dvalid) run++; else run = 0;
            if (run > max_run) max_run = run;
            if (dvalid && dready) begin
                popped++;
                if (exp_q.size() == 0) begin
                    fail("extra_byte", 32'(dout));
                end else begin
                    m_e = exp_q.pop_front();
                    check("dout", 32'(dout), 32'(m_e.dat));
                    check("dlast", 32'(dlast), 32'(m_e.last));
                end
                if (rx_cnt == 0) first_dout = dout;
                if (dlast) begin
                    last_dout = dout;
                    dlast_cnt++;
                end
                rx_cnt++;
            end
            stall_prev = dvalid && !dready;
            stall_dout = dout;
            stall_last = dlast;
            if (done) done_cnt++;
            if (dut.u_fifo.push && dut.u_fifo.full) fail("fifo_overflow", 32'(dut.u_fifo.count));
        end
        if (start && len > 10'd512) fail("len_range", 32'(len));
    end

    // Caller is at posedge+1; returns at posedge+1.
    task automatic run_vec(input vec_t v);
        int cyc;
        push_exp(v.base, v.len);
        clear_stats();
        start = 1'b1; base_addr = v.base; len = v.len; dready = (v.mode == 0);
        cyc = 0;
        while (done_cnt == 0 && cyc < 3000) begin
            @(posedge clk);
            if (v.mode == 2 && cyc == 13) begin
                check("hold_ram_en", 32'(ram_en_s), 0);
                check("hold_pending", 32'(outstanding_s), 4);
            end
            #1;
            cyc++;
            start = v.poke && (cyc == 5);
            if (start) begin
                base_addr = 9'h155;
                len = 10'd3;
            end
            case (v.mode)
                0: dready = 1'b1;
                2: dready = (cyc >= 4 && cyc <= 13) ? 1'b0 : 1'($urandom_range(0, 1));
                default: dready = 1'($urandom_range(0, 1));
            endcase
        end
        if (done_cnt == 0) fail("timeout_done", 32'(cyc));
        start = 1'b0;
        dready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rx_count", 32'(rx_cnt), 32'(v.len));
        check("first_byte", 32'(first_dout), 32'(v.first));
        check("last_byte", 32'(last_dout), 32'(v.lastb));
        check("dlast_count", 32'(dlast_cnt), 1);
        check("done_count", 32'(done_cnt), 1);
        check("exp_left", 32'(exp_q.size()), 0);
        check("addr_left", 32'(addr_q.size()), 0);
        check("busy_end", 32'(busy), 0);
        if (v.mode == 0) check("streak", 32'(max_run), 32'(v.len));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int a = 0; a < 512; a++) mem[a] = 8'(a);
        //                    busy  ram_en dvalid dout   dlast done
        basic_tab[0] = {1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0};
        basic_tab[1] = {1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0};
        basic_tab[2] = {1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0};
        basic_tab[3] = {1'b1, 1'b1, 1'b1, 8'h10, 1'b0, 1'b0};
        basic_tab[4] = {1'b1, 1'b1, 1'b1, 8'h11, 1'b0, 1'b0};
        basic_tab[5] = {1'b1, 1'b0, 1'b1, 8'h12, 1'b0, 1'b0};
        basic_tab[6] = {1'b1, 1'b0, 1'b1, 8'h13, 1'b1, 1'b0};
        basic_tab[7] = {1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1};
        basic_tab[8] = {1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0};
        vecs[0] = '{9'h1FE, 10'd4,   0, 1'b0, 8'hFE, 8'h01};
        vecs[1] = '{9'h020, 10'd8,   2, 1'b0, 8'h20, 8'h27};
        vecs[2] = '{9'h100, 10'd512, 0, 1'b0, 8'h00, 8'hFF};
        vecs[3] = '{9'h1F0, 10'd40,  1, 1'b1, 8'hF0, 8'h17};
        vecs[4] = '{9'h005, 10'd1,   0, 1'b0, 8'h05, 8'h05};

        #1 rst_n = 1'b0;
        #2 check("reset_outputs", 32'({busy, done, ram_en, ram_we, ram_addr, dout, dvalid, dlast}), 0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        clear_stats();
        mon_en = 1'b1;

        // Cycle-exact basic burst.
        @(posedge clk); #1;
        push_exp(9'h010, 10'd4);
        start = 1'b1; base_addr = 9'h010; len = 10'd4; dready = 1'b1;
        for (int c = 0; c < 9; c++) begin
            @(negedge clk);
            check($sformatf("basic_c%0d", c), 32'({busy, ram_en, dvalid, dout, dlast, done}), 32'(basic_tab[c]));
            @(posedge clk); #1;
            start = 1'b0;
        end
        check("basic_done_count", 32'(done_cnt), 1);
        check("basic_exp_left", 32'(exp_q.size()), 0);

        // Zero-length request.
        clear_stats();
        start = 1'b1; base_addr = 9'h0AA; len = 10'd0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check($sformatf("zero_c%0d", c), 32'({busy, ram_en, dvalid, done}), 32'(c == 1));
            @(posedge clk); #1;
            start = 1'b0;
        end
        check("zero_done_count", 32'(done_cnt), 1);
        check("zero_issued", 32'(issued), 0);

        for (int i = 0; i < 5; i++) run_vec(vecs[i]);

        // Asynchronous reset with bytes waiting in the FIFO.
        mon_en = 1'b0;
        start = 1'b1; base_addr = 9'h040; len = 10'd20; dready = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("pre_rst_dvalid", 32'(dvalid), 1);
        #2 rst_n = 1'b0;
        #1 check("midrst_outputs", 32'({busy, done, ram_en, ram_we, ram_addr, dout, dvalid, dlast}), 0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        exp_q.delete();
        addr_q.delete();
        clear_stats();
        mon_en = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("post_rst_quiet", 32'({done_cnt[7:0], max_run[7:0]}), 0);
        run_vec('{9'h033, 10'd2, 0, 1'b0, 8'h33, 8'h34});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
